alu_pipe: RTL

- Parametrised, pipelined successor to the team's 8-bit combinational ALU: DATA_WIDTH operands, 16 opcodes, full status flags.
- Adds a sticky carry/borrow flag so ADDC/SUBB can chain multi-word arithmetic.
- Two register stages with valid/ready handshake on both sides.
- Sits between an operand sequencer and a result sink; throughput one op/cycle when unstalled.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_core.sv | 97 +++++++++
 rtl/alu_pipe.sv | 90 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and status-flag bundle for the pipelined ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_ADDC = 4'd2,
    OP_SUBB = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOT  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_SRA  = 4'd10,
    OP_ROL  = 4'd11,
    OP_ROR  = 4'd12,
    OP_INC  = 4'd13,
    OP_DEC  = 4'd14,
    OP_CMP  = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic cout;
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;

  // Only the add/subtract family feeds the sticky carry used by ADDC/SUBB.
  function automatic logic updates_cf(alu_op_e op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDC, OP_SUBB, OP_INC, OP_DEC, OP_CMP: updates_cf = 1'b1;
      default:                                                  updates_cf = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and status flags from operands, opcode and sticky carry.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            mode,
  input  logic                  cf,
  output logic [DATA_WIDTH-1:0] result,
  output alu_flags_t            flags
);

  localparam int W       = DATA_WIDTH;
  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  alu_op_e               op;
  logic [SHAMT_W-1:0]    sh;
  logic [SHAMT_W-1:0]    rot;
  logic [W-1:0]          addend;
  logic [W-1:0]          subtr;
  logic [W:0]            add_ext;
  logic [W:0]            sub_ext;
  logic [W:0]            shl_ext;
  logic [W:0]            shr_ext;
  logic signed [W:0]     sra_ext;
  logic [W-1:0]          rol_v;
  logic [W-1:0]          ror_v;

  always_comb begin
    op      = alu_op_e'(mode);
    sh      = b[SHAMT_W-1:0];
    rot     = SHAMT_W'(sh % DATA_WIDTH);
    addend  = (op == OP_INC) ? W'(1) : b;
    subtr   = (op == OP_DEC) ? W'(1) : b;
    // Extra bit on each side catches carry/borrow and the last bit shifted out.
    add_ext = {1'b0, a} + {1'b0, addend} + {{W{1'b0}}, (op == OP_ADDC) & cf};
    sub_ext = {1'b0, a} - {1'b0, subtr} - {{W{1'b0}}, (op == OP_SUBB) & cf};
    shl_ext = {1'b0, a} << sh;
    shr_ext = {a, 1'b0} >> sh;
    sra_ext = $signed({a, 1'b0}) >>> sh;
    rol_v   = (a << rot) | (a >> (W - int'(rot)));
    ror_v   = (a >> rot) | (a << (W - int'(rot)));

    result     = '0;
    flags.cout = 1'b0;
    flags.ovf  = 1'b0;
    case (op)
      OP_ADD, OP_ADDC, OP_INC: begin
        result     = add_ext[W-1:0];
        flags.cout = add_ext[W];
        flags.ovf  = (a[W-1] == addend[W-1]) && (add_ext[W-1] != a[W-1]);
      end
      OP_SUB, OP_SUBB, OP_DEC, OP_CMP: begin
        result     = (op == OP_CMP) ? a : sub_ext[W-1:0];
        flags.cout = sub_ext[W];
        flags.ovf  = (a[W-1] != subtr[W-1]) && (sub_ext[W-1] != a[W-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result     = shl_ext[W-1:0];
        flags.cout = shl_ext[W];
      end
      OP_SHR: begin
        result     = shr_ext[W:1];
        flags.cout = shr_ext[0];
      end
      OP_SRA: begin
        result     = sra_ext[W:1];
        flags.cout = sra_ext[0];
      end
      OP_ROL: begin
        result     = rol_v;
        flags.cout = (sh != '0) && rol_v[0];
      end
      OP_ROR: begin
        result     = ror_v;
        flags.cout = (sh != '0) && ror_v[W-1];
      end
      default: result = '0;
    endcase

    // CMP reports a==b and the sign of a-b while passing a through.
    if (op == OP_CMP) begin
      flags.zero = (sub_ext[W-1:0] == '0);
      flags.neg  = sub_ext[W-1];
    end else begin
      flags.zero = (result == '0);
      flags.neg  = result[W-1];
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with a sticky carry for multi-word ADDC/SUBB chains.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [3:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_alu,
  output logic                  out_cout,
  output logic                  out_zero,
  output logic                  out_neg,
  output logic                  out_ovf
);

  logic                  vld_p1;
  logic                  vld_p2;
  logic [DATA_WIDTH-1:0] a_p1;
  logic [DATA_WIDTH-1:0] b_p1;
  logic [3:0]            mode_p1;
  logic [DATA_WIDTH-1:0] alu_p2;
  alu_flags_t            flags_p2;
  logic                  cf_q;
  logic [DATA_WIDTH-1:0] res_c;
  alu_flags_t            flags_c;
  logic                  s2_free;
  logic                  move;
  logic                  push;

  assign s2_free  = !vld_p2 || out_ready;
  assign move     = vld_p1 && s2_free;
  assign in_ready = !vld_p1 || s2_free;
  assign push     = in_valid && in_ready;

  // Stage p0 -> p1: capture operands on an input transfer.
  always_ff @(posedge clk) begin
    if (push) begin
      a_p1    <= in_a;
      b_p1    <= in_b;
      mode_p1 <= in_mode;
    end
  end

  alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .a      (a_p1),
    .b      (b_p1),
    .mode   (mode_p1),
    .cf     (cf_q),
    .result (res_c),
    .flags  (flags_c)
  );

  // Stage p1 -> p2: register the result; cf advances in op order so chains need no bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      alu_p2   <= '0;
      flags_p2 <= '0;
      cf_q     <= 1'b0;
    end else begin
      if (push)      vld_p1 <= 1'b1;
      else if (move) vld_p1 <= 1'b0;

      if (move) begin
        vld_p2   <= 1'b1;
        alu_p2   <= res_c;
        flags_p2 <= flags_c;
        if (updates_cf(alu_op_e'(mode_p1))) cf_q <= flags_c.cout;
      end else if (out_ready) begin
        vld_p2 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_alu   = alu_p2;
  assign out_cout  = flags_p2.cout;
  assign out_zero  = flags_p2.zero;
  assign out_neg   = flags_p2.neg;
  assign out_ovf   = flags_p2.ovf;

endmodule
